// File: rtl/leb128_decoder.sv
// Streaming LEB128 immediate decoder: one command selects signedness and target width,
// then bytes are accumulated until the terminating byte and a single result is emitted.
module leb128_decoder #(
    parameter int unsigned STALL_LIMIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_signed,
    input  logic        cmd_is64,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_value,
    output logic [3:0]  out_len,
    output logic [1:0]  out_error
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [31:0] STALL_LIM = 32'(STALL_LIMIT);

    state_t      state;
    state_t      state_next;
    logic        mode_signed;
    logic        mode_is64;
    logic [63:0] acc;
    logic [3:0]  len;
    logic [31:0] stall_cnt;

    logic [6:0]  byte_shift;
    logic [6:0]  sext_shift;
    logic [3:0]  len_next;
    logic [3:0]  max_len;
    logic        at_max;
    logic        pad_ok;
    logic        sext_en;
    logic        stall_hit;
    logic [63:0] acc_next;
    logic [63:0] final_value;
    logic        load;
    logic [63:0] res_value;
    logic [3:0]  res_len;
    logic [1:0]  res_error;

    // Byte-level datapath: where the incoming 7 payload bits land and how the result is finished.
    always_comb begin
        len_next    = len + 4'd1;
        byte_shift  = 7'(len) * 7'd7;
        sext_shift  = 7'(len_next) * 7'd7;
        max_len     = mode_is64 ? 4'd10 : 4'd5;
        at_max      = (len_next == max_len);
        acc_next    = acc | ({57'd0, in_data[6:0]} << byte_shift);
        sext_en     = mode_signed && in_data[6] &&
                      (sext_shift < (mode_is64 ? 7'd64 : 7'd32));
        final_value = (acc_next | (sext_en ? (~64'd0 << sext_shift) : 64'd0)) &
                      (mode_is64 ? ~64'd0 : 64'h0000_0000_FFFF_FFFF);
        stall_hit   = (STALL_LIMIT != 0) && (stall_cnt == STALL_LIM - 32'd1);
        unique case ({mode_is64, mode_signed})
            2'b00:   pad_ok = (in_data[6:4] == 3'd0);
            2'b01:   pad_ok = (in_data[6:4] == {3{in_data[3]}});
            2'b10:   pad_ok = (in_data[6:1] == 6'd0);
            default: pad_ok = (in_data[6:1] == {6{in_data[0]}});
        endcase
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        res_value  = 64'd0;
        res_len    = len_next;
        res_error  = 2'd0;
        case (state)
            IDLE: begin
                cmd_ready = reset;
                if (cmd_valid && reset) state_next = ACCUM;
            end
            ACCUM: begin
                in_ready = reset;
                if (in_valid) begin
                    if (!in_data[7] || at_max) begin
                        state_next = DONE;
                        load       = 1'b1;
                        if (in_data[7])                res_error = 2'd1;
                        else if (at_max && !pad_ok)    res_error = 2'd2;
                        else                           res_value = final_value;
                    end
                end else if (stall_hit) begin
                    state_next = DONE;
                    load       = 1'b1;
                    res_len    = len;
                    res_error  = 2'd3;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_signed <= 1'b0;
            mode_is64   <= 1'b0;
            acc         <= 64'd0;
            len         <= 4'd0;
            stall_cnt   <= 32'd0;
            out_value   <= 64'd0;
            out_len     <= 4'd0;
            out_error   <= 2'd0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                mode_signed <= cmd_signed;
                mode_is64   <= cmd_is64;
                acc         <= 64'd0;
                len         <= 4'd0;
                stall_cnt   <= 32'd0;
            end
            if (state == ACCUM) begin
                if (in_valid) begin
                    acc       <= acc_next;
                    len       <= len_next;
                    stall_cnt <= 32'd0;
                end else begin
                    stall_cnt <= stall_cnt + 32'd1;
                end
            end
            if (load) begin
                out_value <= res_value;
                out_len   <= res_len;
                out_error <= res_error;
            end
        end
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// Scoreboard bench for leb128_decoder: directed decodes push expected results,
// a negedge monitor pops and compares on every accepted result.
module tb_leb128_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_signed;
    logic        cmd_is64;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic [1:0]  out_error;

    leb128_decoder #(.STALL_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_signed (cmd_signed),
        .cmd_is64   (cmd_is64),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_value  (out_value),
        .out_len    (out_len),
        .out_error  (out_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] value;
        logic [3:0]  len;
        logic [1:0]  err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] bq[$];
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_result", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("out_value", out_value, e.value);
                check("out_len", {60'd0, out_len}, {60'd0, e.len});
                check("out_error", {62'd0, out_error}, {62'd0, e.err});
            end
        end
    end

    task automatic send_cmd(input logic s, input logic w);
        int t;
        t = 0;
        cmd_signed = s;
        cmd_is64   = w;
        cmd_valid  = 1'b1;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_accept", {63'd0, cmd_ready}, 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("byte_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run(input logic s, input logic w, input logic [63:0] v,
                       input logic [3:0] l, input logic [1:0] e);
        exp_t x;
        x.value = v;
        x.len   = l;
        x.err   = e;
        sb.push_back(x);
        send_cmd(s, w);
        foreach (bq[i]) send_byte(bq[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int cyc;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_signed = 1'b0;
        cmd_is64   = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'd0;
        out_ready  = 1'b1;
        cmd_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_value", out_value, 64'd0);
        check("rst_out_len", {60'd0, out_len}, 64'd0);
        check("rst_out_error", {62'd0, out_error}, 64'd0);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned 32 multi-byte, plus one-cycle result latency.
        bq = '{8'hE5, 8'h8E, 8'h26};
        run(1'b0, 1'b0, 64'h0000_0000_0009_8765, 4'd3, 2'd0);
        check("latency_out_valid", {63'd0, out_valid}, 64'd1);

        bq = '{8'h7F};
        run(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd1, 2'd0);
        bq = '{8'h3F};
        run(1'b1, 1'b0, 64'h0000_0000_0000_003F, 4'd1, 2'd0);
        bq = '{8'hC0, 8'hBB, 8'h78};
        run(1'b1, 1'b1, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 2'd0);

        // Final-byte padding at the 32-bit boundary.
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        run(1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5, 2'd0);
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
        run(1'b0, 1'b0, 64'd0, 4'd5, 2'd2);
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
        run(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd5, 2'd0);
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        run(1'b1, 1'b0, 64'd0, 4'd5, 2'd2);

        // 64-bit boundary: full-length -1, then too-long, then a short follow-up.
        bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
        run(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 2'd0);
        bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        run(1'b0, 1'b1, 64'd0, 4'd10, 2'd1);
        bq = '{8'h05};
        run(1'b0, 1'b1, 64'd5, 4'd1, 2'd0);

        // Output backpressure with a command and a byte offered during DONE.
        @(posedge clk);
        #1 out_ready = 1'b0;
        bq = '{8'h01};
        run(1'b0, 1'b0, 64'd1, 4'd1, 2'd0);
        cmd_valid = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_out_value", out_value, 64'd1);
            check("hold_out_len", {60'd0, out_len}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of a decode discards it.
        send_cmd(1'b0, 1'b0);
        send_byte(8'h81);
        send_byte(8'h82);
        reset     = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        reset     = 1'b1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        bq = '{8'h2A};
        run(1'b0, 1'b0, 64'h2A, 4'd1, 2'd0);

        // Stall timeout after one continuation byte.
        bq = '{8'h80};
        run(1'b0, 1'b0, 64'd0, 4'd1, 2'd3);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("stall_latency", 64'(cyc), 64'd4);

        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
